// File: rtl/mcctr_pkg.sv
// ---------------------------------------------------------------------------
// mcctr_pkg
// Shared definitions for the multi-cycle MIPS main controller:
//   - state_t   : controller state encoding (also exported on o_state)
//   - OP_*      : supported IR[31:26] opcodes
//   - ALUOP_*, SRCB_*, PCSRC_* : datapath mux / ALU encodings
//   - ctrl_t    : the per-state control word produced by mcctr_decode
// The ADDIEX/ADDIWB states always exist in the encoding; they are only
// reachable when MCCTR_ADDI_EN is defined.
// ---------------------------------------------------------------------------
package mcctr_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mcctr_decode.sv
// ---------------------------------------------------------------------------
// mcctr_decode
// Purely combinational state -> control-word decode for multi_cycle_ctr.
// Ports:
//   i_state     in   current controller state
//   i_mem_ready in   memory handshake (only affects FETCH and MEMWR outputs)
//   o_ctrl      out  control word; every field not named for a state is 0
// Optional feature: MCCTR_ADDI_EN adds the ADDIEX/ADDIWB decodes.
// ---------------------------------------------------------------------------
module mcctr_decode
    import mcctr_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                // IR and PC only load once the instruction word is valid.
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            ST_DECODE: begin
                // Speculative branch target (PC+4 + imm<<2) into aluOut.
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.ior_d    = 1'b1;
            end
            ST_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            ST_MEMWR: begin
                o_ctrl.mem_write  = 1'b1;
                o_ctrl.ior_d      = 1'b1;
                o_ctrl.instr_done = i_mem_ready;
            end
            ST_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REGB;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_REGB;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
                o_ctrl.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_source  = PCSRC_JUMP;
                o_ctrl.instr_done = 1'b1;
            end
`ifdef MCCTR_ADDI_EN
            ST_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_ADDIWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
`endif
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctr.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctr
// Main controller of the multi-cycle MIPS core. Sequences the shared ALU,
// register file, unified memory port, IR and PC for R-type, lw, sw, beq, j.
// Optional feature: define MCCTR_ADDI_EN to support addi (opcode 001000);
// otherwise 001000 is treated as illegal.
// Ports:
//   i_clk            in   core clock, rising edge
//   i_rst_n          in   asynchronous active-low reset
//   i_op_code[5:0]   in   IR[31:26], used in DECODE and MEMADR
//   i_mem_ready      in   memory completes the access this cycle
//   o_pc_write       out  unconditional PC load
//   o_pc_write_cond  out  PC load if ALU zero
//   o_ior_d          out  memory address select: 0=PC, 1=aluOut
//   o_mem_read       out  memory read strobe
//   o_mem_write      out  memory write strobe
//   o_ir_write       out  IR load
//   o_mem_to_reg     out  write-back data: 1=memory
//   o_reg_dst        out  write-back register: 1=rd, 0=rt
//   o_reg_write      out  register-file write
//   o_alu_src_a      out  0=PC, 1=regA
//   o_alu_src_b[1:0] out  00=regB, 01=4, 10=imm, 11=imm<<2
//   o_alu_op[1:0]    out  00=add, 01=sub, 10=funct
//   o_pc_source[1:0] out  00=ALU, 01=aluOut, 10=jump target
//   o_instr_done     out  pulse in last cycle of a completed instruction
//   o_illegal_op     out  pulse in DECODE for an unsupported opcode
//   o_state[3:0]     out  current state encoding (debug)
// ---------------------------------------------------------------------------
module multi_cycle_ctr
    import mcctr_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_op_code,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic       o_ior_d,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_source,
    output logic       o_instr_done,
    output logic       o_illegal_op,
    output logic [3:0] o_state
);

    state_t r_state;
    state_t w_state_next;
    logic   w_illegal;
    ctrl_t  w_ctrl;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; illegal-opcode detection lives here because it is
    // a function of the opcode, not of the state alone.
    always_comb begin
        w_state_next = r_state;
        w_illegal    = 1'b0;
        case (r_state)
            ST_FETCH:  if (i_mem_ready) w_state_next = ST_DECODE;
            ST_DECODE: begin
                case (i_op_code)
                    OP_RTYPE:     w_state_next = ST_EXEC;
                    OP_LW, OP_SW: w_state_next = ST_MEMADR;
                    OP_BEQ:       w_state_next = ST_BRANCH;
                    OP_J:         w_state_next = ST_JUMP;
`ifdef MCCTR_ADDI_EN
                    OP_ADDI:      w_state_next = ST_ADDIEX;
`endif
                    default: begin
                        w_illegal    = 1'b1;
                        w_state_next = ST_FETCH;
                    end
                endcase
            end
            // Only lw/sw reach MEMADR and IR holds the opcode stable.
            ST_MEMADR: w_state_next = (i_op_code == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  if (i_mem_ready) w_state_next = ST_MEMWB;
            ST_MEMWR:  if (i_mem_ready) w_state_next = ST_FETCH;
            ST_EXEC:   w_state_next = ST_ALUWB;
            ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_JUMP: w_state_next = ST_FETCH;
`ifdef MCCTR_ADDI_EN
            ST_ADDIEX: w_state_next = ST_ADDIWB;
            ST_ADDIWB: w_state_next = ST_FETCH;
`endif
            default:   w_state_next = ST_FETCH;
        endcase
    end

    mcctr_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (i_mem_ready),
        .o_ctrl      (w_ctrl)
    );

    // Output logic. Strobes are gated by reset directly so that a write
    // already in progress is dropped the moment i_rst_n falls, and FETCH's
    // read strobe stays quiet until reset is released.
    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_ior_d         = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_dst       = 1'b0;
        o_reg_write     = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = 2'b00;
        o_alu_op        = 2'b00;
        o_pc_source     = 2'b00;
        o_instr_done    = 1'b0;
        o_illegal_op    = 1'b0;
        if (i_rst_n) begin
            o_pc_write      = w_ctrl.pc_write;
            o_pc_write_cond = w_ctrl.pc_write_cond;
            o_ior_d         = w_ctrl.ior_d;
            o_mem_read      = w_ctrl.mem_read;
            o_mem_write     = w_ctrl.mem_write;
            o_ir_write      = w_ctrl.ir_write;
            o_mem_to_reg    = w_ctrl.mem_to_reg;
            o_reg_dst       = w_ctrl.reg_dst;
            o_reg_write     = w_ctrl.reg_write;
            o_alu_src_a     = w_ctrl.alu_src_a;
            o_alu_src_b     = w_ctrl.alu_src_b;
            o_alu_op        = w_ctrl.alu_op;
            o_pc_source     = w_ctrl.pc_source;
            o_instr_done    = w_ctrl.instr_done;
            o_illegal_op    = w_illegal;
        end
    end

    assign o_state = r_state;

endmodule

// File: tb/tb_multi_cycle_ctr.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_ctr
// Self-checking bench for multi_cycle_ctr. A reference model expands each
// instruction (kind + memory wait counts) into the list of cycles it must
// take, with the memReady value to drive and the full expected output set
// for every cycle. Directed instructions come first, then random ones.
// Honours MCCTR_ADDI_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctr;
    import mcctr_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, psrc;
        logic       done, ill;
    } obs_t;

    typedef struct {
        logic       rdy;
        logic [5:0] op;
        obs_t       e;
    } step_t;

    typedef enum int {K_R, K_LW, K_SW, K_BEQ, K_J, K_ADDI, K_BAD} kind_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op_code = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
    logic [3:0] state;
    obs_t       obs;

    int n_checks = 0;
    int n_fail   = 0;
    int step_no  = 0;
    step_t q[$];

    always #5 clk = ~clk;

    multi_cycle_ctr dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_op_code       (op_code),
        .i_mem_ready     (mem_ready),
        .o_pc_write      (pc_write),
        .o_pc_write_cond (pc_write_cond),
        .o_ior_d         (ior_d),
        .o_mem_read      (mem_read),
        .o_mem_write     (mem_write),
        .o_ir_write      (ir_write),
        .o_mem_to_reg    (mem_to_reg),
        .o_reg_dst       (reg_dst),
        .o_reg_write     (reg_write),
        .o_alu_src_a     (alu_src_a),
        .o_alu_src_b     (alu_src_b),
        .o_alu_op        (alu_op),
        .o_pc_source     (pc_source),
        .o_instr_done    (instr_done),
        .o_illegal_op    (illegal_op),
        .o_state         (state)
    );

    assign obs = {state, pc_write, pc_write_cond, ior_d, mem_read, mem_write,
                  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                  alu_src_b, alu_op, pc_source, instr_done, illegal_op};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic bit op_supported(input logic [5:0] op);
        bit ok;
        ok = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
             (op == 6'b000100) || (op == 6'b000010);
`ifdef MCCTR_ADDI_EN
        if (op == 6'b001000) ok = 1'b1;
`endif
        return ok;
    endfunction

    function automatic void add(input logic rdy, input logic [5:0] op, input obs_t e);
        step_t s;
        s.rdy = rdy;
        s.op  = op;
        s.e   = e;
        q.push_back(s);
    endfunction

    // Expand one instruction into its expected cycles. wf = FETCH wait
    // cycles, wm = MEMRD/MEMWR wait cycles.
    function automatic void build(input kind_t k, input logic [5:0] op, input int wf, input int wm);
        obs_t e;
        for (int i = 0; i < wf; i++) begin
            e = '0; e.st = ST_FETCH; e.mr = 1; e.asb = 2'b01;
            add(1'b0, 6'($urandom), e);
        end
        e = '0; e.st = ST_FETCH; e.mr = 1; e.asb = 2'b01; e.irw = 1; e.pcw = 1;
        add(1'b1, 6'($urandom), e);
        e = '0; e.st = ST_DECODE; e.asb = 2'b11; e.ill = !op_supported(op);
        add(1'($urandom), op, e);
        if (!op_supported(op)) return;
        case (k)
            K_LW, K_SW: begin
                e = '0; e.st = ST_MEMADR; e.asa = 1; e.asb = 2'b10;
                add(1'($urandom), op, e);
                for (int i = 0; i <= wm; i++) begin
                    e = '0; e.iord = 1;
                    if (k == K_LW) begin e.st = ST_MEMRD; e.mr = 1; end
                    else begin e.st = ST_MEMWR; e.mw = 1; e.done = (i == wm); end
                    add(i == wm, op, e);
                end
                if (k == K_LW) begin
                    e = '0; e.st = ST_MEMWB; e.rw = 1; e.m2r = 1; e.done = 1;
                    add(1'($urandom), op, e);
                end
            end
            K_R: begin
                e = '0; e.st = ST_EXEC; e.asa = 1; e.aop = 2'b10;
                add(1'($urandom), op, e);
                e = '0; e.st = ST_ALUWB; e.rw = 1; e.rdst = 1; e.done = 1;
                add(1'($urandom), op, e);
            end
            K_BEQ: begin
                e = '0; e.st = ST_BRANCH; e.asa = 1; e.aop = 2'b01; e.pcwc = 1;
                e.psrc = 2'b01; e.done = 1;
                add(1'($urandom), op, e);
            end
            K_J: begin
                e = '0; e.st = ST_JUMP; e.pcw = 1; e.psrc = 2'b10; e.done = 1;
                add(1'($urandom), op, e);
            end
            K_ADDI: begin
                e = '0; e.st = ST_ADDIEX; e.asa = 1; e.asb = 2'b10;
                add(1'($urandom), op, e);
                e = '0; e.st = ST_ADDIWB; e.rw = 1; e.done = 1;
                add(1'($urandom), op, e);
            end
            default: ;
        endcase
    endfunction

    function automatic logic [5:0] op_of(input kind_t k);
        logic [5:0] op;
        case (k)
            K_R:    op = 6'b000000;
            K_LW:   op = 6'b100011;
            K_SW:   op = 6'b101011;
            K_BEQ:  op = 6'b000100;
            K_J:    op = 6'b000010;
            K_ADDI: op = 6'b001000;
            default: begin
                op = 6'($urandom);
                while (op_supported(op) || op == 6'b001000) op = 6'($urandom);
            end
        endcase
        return op;
    endfunction

    // Drive and check up to max_n queued cycles, one line per cycle.
    task automatic run_steps(input int max_n);
        step_t s;
        int n = 0;
        while (q.size() > 0 && n < max_n) begin
            s = q.pop_front();
            @(negedge clk);
            op_code   = s.op;
            mem_ready = s.rdy;
            #1;
            $display("step %0d op=%b rdy=%0d state=%0d obs=%h exp=%h",
                     step_no, s.op, s.rdy, state, obs, s.e);
            check_val($sformatf("step%0d_st%0d", step_no, s.e.st), 32'(obs), 32'(s.e));
            step_no++;
            n++;
        end
    endtask

    initial begin
        obs_t z;
        kind_t k;
        z = '0;
        z.st = ST_FETCH;

        // Held in reset: every output quiet, state reads FETCH.
        mem_ready = 1'b1;
        #3;
        check_val("reset_hold", 32'(obs), 32'(z));
        @(negedge clk); #1;
        check_val("reset_hold2", 32'(obs), 32'(z));
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Directed: lw zero-wait, sw with 3 MEMWR waits, R, beq, j, bad, addi.
        build(K_LW,   op_of(K_LW),  0, 0);
        build(K_SW,   op_of(K_SW),  0, 3);
        build(K_R,    op_of(K_R),   0, 0);
        build(K_BEQ,  op_of(K_BEQ), 0, 0);
        build(K_J,    op_of(K_J),   0, 0);
        build(K_BAD,  6'b111111,    0, 0);
        build(K_ADDI, op_of(K_ADDI), 0, 0);
        build(K_LW,   op_of(K_LW),  2, 2);
        run_steps(1000);

        // Reset asserted in the first MEMWR cycle of a stalled sw.
        build(K_SW, op_of(K_SW), 0, 3);
        run_steps(4);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_memwrite", 32'(mem_write), 32'd0);
        check_val("rst_all", 32'(obs), 32'(z));
        q.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Random instruction stream.
        for (int i = 0; i < 40; i++) begin
            k = kind_t'($urandom_range(0, 6));
            build(k, op_of(k), $urandom_range(0, 3), $urandom_range(0, 3));
            run_steps(1000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctr.md
# multi_cycle_ctr

Multi-cycle main controller for the MIPS core: a Moore/Mealy FSM that sequences the shared ALU, register file, unified memory port, IR and PC through fetch, decode, execute, memory and write-back steps for R-type, lw, sw, beq and j. It replaces the single-cycle decoder `ctr` when the datapath shares one memory and one ALU across cycles. A ready handshake stretches memory steps for slow memory.

## Interface
- No parameters.
- clk  in  1  core clock, rising edge
- rstN  in  1  asynchronous active-low reset
- opCode  in  6  IR[31:26], sampled in DECODE
- memReady  in  1  memory completes the access this cycle
- pcWrite, pcWriteCond  out  1  unconditional PC load / load if ALU zero
- iorD  out  1  memory address: 0=PC, 1=aluOut
- memRead, memWrite  out  1  memory strobes
- irWrite  out  1  IR load
- memToReg, regDst, regWrite  out  1  write-back control
- aluSrcA  out  1  0=PC, 1=regA
- aluSrcB  out  2  00=regB, 01=4, 10=signExt(imm), 11=signExt(imm)<<2
- aluOp  out  2  00=add, 01=sub, 10=use funct
- pcSource  out  2  00=ALU result, 01=aluOut, 10=jump target
- instrDone  out  1  one-cycle pulse in last cycle of a completed instruction
- illegalOp  out  1  one-cycle pulse in DECODE for unsupported opcode
- state  out  4  current state encoding, debug

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP (plus ADDIEX, ADDIWB under macro).
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00; irWrite=pcWrite=memReady. Stay while memReady=0; else -> DECODE.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00 (branch target into aluOut). opCode 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP, else illegalOp=1 and -> FETCH.
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00; lw->MEMRD, sw->MEMWR (opCode held stable by IR).
- MEMRD: memRead=1, iorD=1; hold until memReady, then -> MEMWB.
- MEMWB: regWrite=1, memToReg=1, regDst=0, instrDone=1 -> FETCH.
- MEMWR: memWrite=1, iorD=1, instrDone=memReady; hold until memReady, then -> FETCH.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10 -> ALUWB. ALUWB: regWrite=1, regDst=1, memToReg=0, instrDone=1 -> FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01, instrDone=1 -> FETCH.
- JUMP: pcWrite=1, pcSource=10, instrDone=1 -> FETCH.
- Every output not listed for a state is 0.

## Timing
- rstN low: state=FETCH asynchronously; all outputs forced 0 (including FETCH strobes) while rstN=0; state output reads FETCH encoding.
- First FETCH strobes appear in the first cycle with rstN high.
- Zero-wait latencies (memReady=1): R-type 4, lw 5, sw 4, beq 3, j 3 cycles FETCH-to-FETCH.
- Each memReady=0 cycle in FETCH/MEMRD/MEMWR adds one cycle; strobes stay asserted and constant throughout the wait.
- memReady ignored in non-memory states.
- Reset mid-instruction: abort immediately; no write strobe after rstN falls; restart at FETCH.

## Configuration
- MCCTR_ADDI_EN defined: opCode 001000 in DECODE -> ADDIEX (aluSrcA=1, aluSrcB=10, aluOp=00) -> ADDIWB (regWrite=1, regDst=0, memToReg=0, instrDone=1) -> FETCH; 4 cycles.
- Undefined: 001000 is illegal (illegalOp pulse, -> FETCH).

## Structure
- Package mcctr_pkg: state enum, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), aluOp/aluSrcB/pcSource encodings.
- Sub-module mcctr_decode: combinational state+memReady -> control word; top holds the state register and next-state logic.

## Test plan
- Reset: rstN=0 mid-MEMWR -> memWrite drops to 0 same cycle; after release FETCH with memRead=1, iorD=0.
- lw, memReady=1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regWrite&memToReg in cycle 5; instrDone once.
- sw with memReady low 3 cycles in MEMWR -> memWrite high 4 cycles, instrDone only in final cycle; total 7 cycles.
- R-type then beq then j -> 4/3/3 cycles; pcWriteCond=1 with aluOp=01 in BRANCH; pcWrite=1, pcSource=10 in JUMP.
- opCode 111111 -> illegalOp one pulse in DECODE, no regWrite/memWrite, back to FETCH at cycle 3.
- opCode 001000 -> with MCCTR_ADDI_EN regWrite=1, regDst=0 in cycle 4; without it illegalOp=1.
